// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-source MAC TX arbiter.
package tx_arb_pkg;

  typedef enum logic [2:0] {
    CFG_WAIT = 3'd0,
    IDLE     = 3'd1,
    WAIT_ACK = 3'd2,
    STREAM   = 3'd3,
    DRAIN    = 3'd4,
    IFG      = 3'd5
  } arb_state_t;

  localparam int unsigned MAX_LEN_STD   = 1514;
  localparam int unsigned MAX_LEN_JUMBO = 9014;

  // Cycle counter covers CONF_DELAY, ACK_TIMEOUT and IFG_CYCLES.
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LEN_W  = 14;
  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/tx_arb_sat_counter.sv
// Saturating event counter used for per-source frame statistics.
module tx_arb_sat_counter
  import tx_arb_pkg::*;
(
  input  logic              tx_clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [STAT_W-1:0] count_o
);

  logic [STAT_W-1:0] count_q, count_d;

  // Next count: clear wins, otherwise increment until all ones.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tx_mac_arbiter.sv
// Round-robin arbiter sharing one MAC TX byte interface between two frame
// sources, with inter-frame gap, max frame length and ack timeout.
// Optional macro TX_ARB_STATS_EN builds the per-source frame counters.
module tx_mac_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned IFG_CYCLES  = 12,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned JUMBO       = 0,
  parameter int unsigned NO_GEN_CRC  = 0,
  parameter int unsigned CONF_DELAY  = 100
) (
  input  logic        tx_clk,
  input  logic        reset,
  input  logic [7:0]  req0_data,
  input  logic        req0_dvld,
  output logic        req0_ack,
  input  logic [7:0]  req1_data,
  input  logic        req1_dvld,
  output logic        req1_ack,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic [1:0]  grant,
  output logic        err_timeout,
  output logic        err_oversize,
  output logic [15:0] stat_frames0,
  output logic [15:0] stat_frames1
);

  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONF_DELAY - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] IFG_LAST  = CNT_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0] MAX_LEN   = (JUMBO != 0) ? LEN_W'(MAX_LEN_JUMBO)
                                                        : LEN_W'(MAX_LEN_STD);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       grant_q, grant_d;
  logic             last_grant_q, last_grant_d;  // index of source served last
  logic             conf_en_q, conf_en_d;
  logic             inc0, inc1;

  logic             g_idx;
  logic             g_dvld;
  logic [7:0]       g_data;

  assign g_idx  = grant_q[1];
  assign g_dvld = grant_q[1] ? req1_dvld : (grant_q[0] ? req0_dvld : 1'b0);
  assign g_data = grant_q[1] ? req1_data : (grant_q[0] ? req0_data : 8'h00);

  // State and bookkeeping registers; reset drops the MAC frame at once.
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q      <= CFG_WAIT;
      cnt_q        <= '0;
      len_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      conf_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      conf_en_q    <= conf_en_d;
    end
  end

  // Next-state logic: arbitration, ack wait, streaming and gap timing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    conf_en_d    = conf_en_q;
    inc0         = 1'b0;
    inc1         = 1'b0;
    case (state_q)
      CFG_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CONF_LAST) begin
          cnt_d     = '0;
          conf_en_d = 1'b1;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        if (req0_dvld && (!req1_dvld || last_grant_q)) begin
          grant_d = 2'b01;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end else if (req1_dvld) begin
          grant_d = 2'b10;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (g_dvld && mac_tx_ack) begin
          // The acked byte is the first one of the frame, so it is counted.
          len_d   = LEN_W'(1);
          state_d = STREAM;
        end else if (!g_dvld || (cnt_q == ACK_LAST)) begin
          last_grant_d = g_idx;
          grant_d      = '0;
          cnt_d        = '0;
          state_d      = IFG;
        end
      end
      STREAM: begin
        if (!g_dvld) begin
          inc0         = ~g_idx;
          inc1         = g_idx;
          last_grant_d = g_idx;
          grant_d      = '0;
          cnt_d        = '0;
          state_d      = IFG;
        end else if (len_q == MAX_LEN) begin
          state_d = DRAIN;
        end else begin
          len_d = len_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!g_dvld) begin
          last_grant_d = g_idx;
          grant_d      = '0;
          cnt_d        = '0;
          state_d      = IFG;
        end
      end
      IFG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IFG_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IFG;
      end
    endcase
  end

  // Output logic: forward the granted source, raise acks and error pulses.
  always_comb begin
    mac_tx_dvld  = 1'b0;
    mac_tx_data  = 8'h00;
    req0_ack     = 1'b0;
    req1_ack     = 1'b0;
    err_timeout  = 1'b0;
    err_oversize = 1'b0;
    case (state_q)
      WAIT_ACK: begin
        mac_tx_dvld = g_dvld;
        mac_tx_data = g_dvld ? g_data : 8'h00;
        req0_ack    = grant_q[0] & g_dvld & mac_tx_ack;
        req1_ack    = grant_q[1] & g_dvld & mac_tx_ack;
        err_timeout = g_dvld & ~mac_tx_ack & (cnt_q == ACK_LAST);
      end
      STREAM: begin
        if (g_dvld && (len_q == MAX_LEN)) begin
          err_oversize = 1'b1;
        end else begin
          mac_tx_dvld = g_dvld;
          mac_tx_data = g_dvld ? g_data : 8'h00;
        end
      end
      default: begin
        mac_tx_dvld = 1'b0;
      end
    endcase
  end

  assign grant              = grant_q;
  assign conf_tx_en         = conf_en_q;
  assign conf_tx_jumbo_en   = (JUMBO != 0);
  assign conf_tx_no_gen_crc = (NO_GEN_CRC != 0);

`ifdef TX_ARB_STATS_EN
  tx_arb_sat_counter u_stat0 (
    .tx_clk  (tx_clk),
    .reset   (reset),
    .clear_i (1'b0),
    .inc_i   (inc0),
    .count_o (stat_frames0)
  );

  tx_arb_sat_counter u_stat1 (
    .tx_clk  (tx_clk),
    .reset   (reset),
    .clear_i (1'b0),
    .inc_i   (inc1),
    .count_o (stat_frames1)
  );
`else
  logic unused_stats;
  assign unused_stats = inc0 | inc1;
  assign stat_frames0 = '0;
  assign stat_frames1 = '0;
`endif

endmodule

// File: tb/tb_tx_mac_arbiter.sv
// Directed bench for tx_mac_arbiter: two source models, a MAC ack model and
// a negedge monitor feeding hand-derived expectations.
module tb_tx_mac_arbiter;

`ifdef TX_ARB_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        tx_clk = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        req0_dvld = 1'b0, req1_dvld = 1'b0;
  logic        req0_ack, req1_ack;
  logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_ack = 1'b0;
  logic [1:0]  grant;
  logic        err_timeout, err_oversize;
  logic [15:0] stat_frames0, stat_frames1;

  tx_mac_arbiter #(
    .IFG_CYCLES  (12),
    .ACK_TIMEOUT (1024),
    .JUMBO       (0),
    .NO_GEN_CRC  (0),
    .CONF_DELAY  (100)
  ) dut (
    .tx_clk             (tx_clk),
    .reset              (reset),
    .req0_data          (req0_data),
    .req0_dvld          (req0_dvld),
    .req0_ack           (req0_ack),
    .req1_data          (req1_data),
    .req1_dvld          (req1_dvld),
    .req1_ack           (req1_ack),
    .conf_tx_en         (conf_tx_en),
    .conf_tx_jumbo_en   (conf_tx_jumbo_en),
    .conf_tx_no_gen_crc (conf_tx_no_gen_crc),
    .mac_tx_data        (mac_tx_data),
    .mac_tx_dvld        (mac_tx_dvld),
    .mac_tx_ack         (mac_tx_ack),
    .grant              (grant),
    .err_timeout        (err_timeout),
    .err_oversize       (err_oversize),
    .stat_frames0       (stat_frames0),
    .stat_frames1       (stat_frames1)
  );

  initial forever #5 tx_clk = ~tx_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int s, input int i);
    return 8'(i * 7 + s * 101 + 3);
  endfunction

  // monitor / MAC model state
  int cyc = 0;
  bit mac_on = 0;
  int ack_delay = 3;
  bit ack_next = 0;
  int wait_cnt = 0;
  bit in_frame = 0;
  int cur_len = 0;
  bit prev_dvld = 0, prev_to = 0, prev_req0 = 0, have_rise = 0;
  int low_run = 0, min_gap = 9999, rise_cyc = 0;
  int byte_errs = 0, idle_data_errs = 0, bad_ack = 0;
  int ack0_cnt = 0, ack1_cnt = 0, to_cnt = 0, ov_cnt = 0;
  int to_delta = -1, grant_after_to = -1, req0_fall_cyc = 0;
  int grant_log[$];
  int len_log[$];

  bit src_kill = 0;
  bit src_active [2];

  initial forever begin
    @(posedge tx_clk);
    cyc++;
  end

  initial forever begin
    @(posedge tx_clk);
    #1 mac_tx_ack = ack_next;
  end

  initial forever begin
    int owner;
    @(negedge tx_clk);
    owner = (grant == 2'b10) ? 1 : 0;
    if (mac_tx_dvld && (mac_tx_ack || in_frame)) begin
      if (mac_tx_data !== byte_of(owner, cur_len)) byte_errs++;
      cur_len++;
    end
    if (mac_tx_dvld && mac_tx_ack) in_frame = 1;
    if (!mac_tx_dvld) begin
      if (in_frame) begin
        len_log.push_back(cur_len);
        in_frame = 0;
      end
      cur_len = 0;
      if (mac_tx_data !== 8'h00) idle_data_errs++;
      low_run++;
    end else if (!prev_dvld) begin
      grant_log.push_back(owner);
      if (have_rise && low_run < min_gap) min_gap = low_run;
      have_rise = 1;
      rise_cyc  = cyc;
      low_run   = 0;
    end
    if (req0_ack) begin
      ack0_cnt++;
      if (grant != 2'b01 || !mac_tx_ack) bad_ack++;
    end
    if (req1_ack) begin
      ack1_cnt++;
      if (grant != 2'b10 || !mac_tx_ack) bad_ack++;
    end
    if (err_timeout) begin
      if (to_cnt == 0) to_delta = cyc - rise_cyc;
      to_cnt++;
    end
    if (prev_to) grant_after_to = int'(grant);
    prev_to = err_timeout;
    if (err_oversize) ov_cnt++;
    if (prev_req0 && !req0_dvld) req0_fall_cyc = cyc;
    prev_req0 = req0_dvld;
    if (!mac_on || !mac_tx_dvld || in_frame) wait_cnt = 0;
    else wait_cnt++;
    ack_next  = mac_on && (wait_cnt == ack_delay);
    prev_dvld = mac_tx_dvld;
  end

  function automatic void clear_mon();
    grant_log.delete();
    len_log.delete();
    min_gap = 9999; have_rise = 0; low_run = 0; byte_errs = 0;
    ack0_cnt = 0; ack1_cnt = 0; to_cnt = 0; ov_cnt = 0;
    to_delta = -1; grant_after_to = -1;
  endfunction

  function automatic int log_at(input int i);
    return (i < grant_log.size()) ? grant_log[i] : -1;
  endfunction

  function automatic int len_at(input int i);
    return (i < len_log.size()) ? len_log[i] : -1;
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    if (s == 0) begin
      req0_dvld = v;
      req0_data = v ? d : 8'h00;
    end else begin
      req1_dvld = v;
      req1_data = v ? d : 8'h00;
    end
  endtask

  // Source model: present byte 0 until acked, then one byte per cycle.
  task automatic src_frame(input int s, input int n, input int max_wait);
    int w = 0;
    bit acked = 0;
    src_active[s] = 1;
    drive(s, 1'b1, byte_of(s, 0));
    while (!acked && !src_kill && w < max_wait) begin
      @(negedge tx_clk);
      if ((s == 0) ? req0_ack : req1_ack) acked = 1;
      w++;
      @(posedge tx_clk);
      #1;
    end
    if (acked) begin
      for (int i = 1; i < n && !src_kill; i++) begin
        drive(s, 1'b1, byte_of(s, i));
        @(posedge tx_clk);
        #1;
      end
    end
    drive(s, 1'b0, 8'h00);
    @(posedge tx_clk);
    #1;
    src_active[s] = 0;
  endtask

  task automatic release_and_wait();
    int k = 0;
    @(posedge tx_clk);
    #1 reset = 1'b0;
    while (!conf_tx_en && k < 300) begin
      @(negedge tx_clk);
      k++;
    end
    check_eq("conf_up", int'(conf_tx_en), 1);
    @(posedge tx_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge tx_clk);
    release_and_wait();
  endtask

  initial begin
    int conf_hi = 0;
    int k;
    repeat (3) @(posedge tx_clk);
    @(negedge tx_clk);
    check_eq("reset_outputs", int'(|{req0_ack, req1_ack, conf_tx_en, conf_tx_jumbo_en,
             conf_tx_no_gen_crc, mac_tx_data, mac_tx_dvld, grant, err_timeout,
             err_oversize, stat_frames0, stat_frames1}), 0);

    // power-up: conf_tx_en low for 100 cycles, high on the 101st
    @(posedge tx_clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge tx_clk);
      if (conf_tx_en) conf_hi++;
    end
    check_eq("conf_early", conf_hi, 0);
    @(negedge tx_clk);
    check_eq("conf_at_101", int'(conf_tx_en), 1);
    check_eq("jumbo_en", int'(conf_tx_jumbo_en), 0);
    check_eq("no_gen_crc", int'(conf_tx_no_gen_crc), 0);

    // single 60-byte frame from source 0, MAC acks 3 cycles after dvld
    @(posedge tx_clk);
    #1;
    clear_mon();
    mac_on = 1;
    fork
      src_frame(0, 60, 500);
      begin
        @(negedge tx_clk);
        check_eq("dvld_before", int'(mac_tx_dvld), 0);
        @(negedge tx_clk);
        check_eq("dvld_rise", int'(mac_tx_dvld), 1);
        repeat (3) @(negedge tx_clk);
        check_eq("ack_with_mac", int'({req0_ack, mac_tx_ack}), 3);
      end
    join
    repeat (20) @(negedge tx_clk);
    #1;
    check_eq("single_len", len_at(0), 60);
    check_eq("single_data", byte_errs, 0);
    check_eq("single_acks", ack0_cnt, 1);
    check_eq("single_grant_idle", int'(grant), 0);
    check_eq("single_stat0", int'(stat_frames0), STATS);

    // both sources, two frames each: round-robin 0,1,0,1
    do_reset();
    clear_mon();
    fork
      begin src_frame(0, 20, 800); src_frame(0, 20, 800); end
      begin src_frame(1, 20, 800); src_frame(1, 20, 800); end
    join
    repeat (5) @(negedge tx_clk);
    #1;
    check_eq("rr_g0", log_at(0), 0);
    check_eq("rr_g1", log_at(1), 1);
    check_eq("rr_g2", log_at(2), 0);
    check_eq("rr_g3", log_at(3), 1);
    check_eq("rr_min_gap", min_gap, 14);
    check_eq("rr_data", byte_errs, 0);
    check_eq("rr_stat0", int'(stat_frames0), 2 * STATS);
    check_eq("rr_stat1", int'(stat_frames1), 2 * STATS);

    // ack timeout on source 1, then source 0 wins
    do_reset();
    clear_mon();
    mac_on = 0;
    fork
      src_frame(1, 10, 1100);
      begin
        repeat (200) @(posedge tx_clk);
        #1;
        src_frame(0, 10, 3000);
      end
      begin
        k = 0;
        while (grant != 2'b01 && k < 2000) begin
          @(negedge tx_clk);
          k++;
        end
        mac_on = 1;
      end
    join
    repeat (30) @(negedge tx_clk);
    #1;
    check_eq("to_count", to_cnt, 1);
    check_eq("to_delay", to_delta, 1023);
    check_eq("to_grant_release", grant_after_to, 0);
    check_eq("to_first", log_at(0), 1);
    check_eq("to_next", log_at(1), 0);
    check_eq("to_ack0", ack0_cnt, 1);

    // oversize: 1600-byte frame truncated at 1514
    do_reset();
    clear_mon();
    mac_on = 1;
    fork
      src_frame(0, 1600, 500);
      begin
        repeat (100) @(posedge tx_clk);
        #1;
        src_frame(1, 10, 3000);
      end
    join
    repeat (5) @(negedge tx_clk);
    #1;
    check_eq("ov_pulses", ov_cnt, 1);
    check_eq("ov_len", len_at(0), 1514);
    check_eq("ov_next_len", len_at(1), 10);
    check_eq("ov_data", byte_errs, 0);
    check_eq("ov_regrant", rise_cyc - req0_fall_cyc, 14);
    check_eq("ov_order", log_at(1), 1);
    check_eq("ov_stat0", int'(stat_frames0), 0);
    check_eq("ov_stat1", int'(stat_frames1), STATS);

    // reset in the middle of a stream
    do_reset();
    clear_mon();
    mac_on = 1;
    src_frame(0, 30, 500);
    fork
      src_frame(0, 40, 500);
    join_none
    k = 0;
    do begin
      @(negedge tx_clk);
      #1;
      k++;
    end while (cur_len < 20 && k < 300);
    check_eq("byte20_reached", int'(cur_len >= 20), 1);
    src_kill = 1;
    reset = 1'b1;
    #1;
    check_eq("async_dvld_drop", int'(mac_tx_dvld), 0);
    check_eq("async_grant", int'(grant), 0);
    check_eq("async_stat0", int'(stat_frames0), 0);
    k = 0;
    while (src_active[0] && k < 50) begin
      @(posedge tx_clk);
      k++;
    end
    check_eq("src_stopped", int'(src_active[0]), 0);
    src_kill = 0;
    check_eq("cfg_after_reset", int'(conf_tx_en), 0);
    release_and_wait();
    clear_mon();
    fork
      src_frame(0, 10, 500);
      src_frame(1, 10, 500);
    join
    repeat (5) @(negedge tx_clk);
    #1;
    check_eq("rst_tie0", log_at(0), 0);
    check_eq("rst_tie1", log_at(1), 1);

    check_eq("ack_only_granted", bad_ack, 0);
    check_eq("idle_data_zero", idle_data_errs, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
